// File: rtl/pc_next_unit.sv
// PC register and next-PC selection for the MIPS fetch stage, with a small
// fetch/halt/trap state machine driving the instruction memory handshake.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] PCBranch,
    input  logic        Jump,
    input  logic [25:0] JumpAddr,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        InstrReady,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        FetchReq,
    output logic        Misaligned,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HALT  = 2'b10,
        TRAP  = 2'b11
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic        accept;

    assign PCplus4 = PC + 32'd4;
    assign State   = state;
    assign accept  = InstrReady && !Stall;

    // Jump outranks a taken branch; the jump region comes from PC+4, not PC.
    always_comb begin
        target = PCplus4;
        if (Jump) begin
            target = {PCplus4[31:28], JumpAddr, 2'b00};
        end else if (Branch && Zero) begin
            target = PCBranch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            PC         <= RESET_PC;
            FetchReq   <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    FetchReq <= 1'b1;
                end
                FETCH: begin
                    if (Halt) begin
                        state    <= HALT;
                        FetchReq <= 1'b0;
                    end else if (accept) begin
                        // A misaligned target leaves PC on the faulting instruction.
                        if (target[1:0] == 2'b00) begin
                            PC <= target;
                        end else begin
                            state      <= TRAP;
                            FetchReq   <= 1'b0;
                            Misaligned <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    FetchReq <= 1'b0;
                end
                TRAP: begin
                    FetchReq   <= 1'b0;
                    Misaligned <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    FetchReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed, table-driven bench for pc_next_unit: sequential/branch/jump vectors
// followed by hand sequences for trap, halt and asynchronous reset.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic        zero;
    logic [31:0] pc_branch;
    logic        jump;
    logic [25:0] jump_addr;
    logic        stall;
    logic        halt;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_req;
    logic        misaligned;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        branch;
        logic        zero;
        logic [31:0] pc_branch;
        logic        jump;
        logic [25:0] jump_addr;
        logic        stall;
        logic        instr_ready;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_plus4;
        logic [1:0]  exp_state;
        logic        exp_fetch_req;
    } vec_t;

    vec_t vecs[$];

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Branch     (branch),
        .Zero       (zero),
        .PCBranch   (pc_branch),
        .Jump       (jump),
        .JumpAddr   (jump_addr),
        .Stall      (stall),
        .Halt       (halt),
        .InstrReady (instr_ready),
        .PC         (pc),
        .PCplus4    (pc_plus4),
        .FetchReq   (fetch_req),
        .Misaligned (misaligned),
        .State      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic z, input logic [31:0] pcb,
                                 input logic j, input logic [25:0] ja,
                                 input logic st, input logic h, input logic ir);
        branch      = b;
        zero        = z;
        pc_branch   = pcb;
        jump        = j;
        jump_addr   = ja;
        stall       = st;
        halt        = h;
        instr_ready = ir;
    endtask

    task automatic addVec(input string name, input logic b, input logic z, input logic [31:0] pcb,
                          input logic j, input logic [25:0] ja, input logic st, input logic ir,
                          input logic [31:0] epc, input logic [31:0] epc4);
        vec_t v;
        v.name = name; v.branch = b; v.zero = z; v.pc_branch = pcb; v.jump = j;
        v.jump_addr = ja; v.stall = st; v.instr_ready = ir; v.exp_pc = epc;
        v.exp_pc_plus4 = epc4; v.exp_state = 2'b01; v.exp_fetch_req = 1'b1;
        vecs.push_back(v);
    endtask

    task automatic checkAll(input string tag, input logic [31:0] epc, input logic [1:0] est,
                            input logic efr, input logic emis);
        checkOutput({tag, "_pc"}, pc, epc);
        checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, est});
        checkOutput({tag, "_fetchreq"}, {31'd0, fetch_req}, {31'd0, efr});
        checkOutput({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, emis});
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //      name           br  z   pcbranch      j   jaddr      st  ir  exp pc        exp pc+4
        addVec("seq0",        0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_0004, 32'h0000_0008);
        addVec("seq1",        0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_0008, 32'h0000_000C);
        addVec("seq2",        0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_000C, 32'h0000_0010);
        addVec("br_taken",    1,  1,  32'h20,       0,  26'h0,     0,  1,  32'h0000_0020, 32'h0000_0024);
        addVec("br_nottaken", 1,  0,  32'h80,       0,  26'h0,     0,  1,  32'h0000_0024, 32'h0000_0028);
        addVec("jump_wins",   1,  1,  32'h200,      1,  26'h40,    0,  1,  32'h0000_0100, 32'h0000_0104);
        addVec("stall0",      0,  0,  32'h0,        0,  26'h0,     1,  1,  32'h0000_0100, 32'h0000_0104);
        addVec("stall1",      0,  0,  32'h0,        0,  26'h0,     1,  1,  32'h0000_0100, 32'h0000_0104);
        addVec("stall2",      0,  0,  32'h0,        0,  26'h0,     1,  1,  32'h0000_0100, 32'h0000_0104);
        addVec("stall_misal", 1,  1,  32'h22,       0,  26'h0,     1,  1,  32'h0000_0100, 32'h0000_0104);
        addVec("notready0",   0,  0,  32'h0,        0,  26'h0,     0,  0,  32'h0000_0100, 32'h0000_0104);
        addVec("notready_j",  0,  0,  32'h0,        1,  26'h3FF,   0,  0,  32'h0000_0100, 32'h0000_0104);
        addVec("resume",      0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_0104, 32'h0000_0108);
        addVec("br_region",   1,  1,  32'h1000_0000,0,  26'h0,     0,  1,  32'h1000_0000, 32'h1000_0004);
        addVec("jump_region", 0,  0,  32'h0,        1,  26'h10,    0,  1,  32'h1000_0040, 32'h1000_0044);
        addVec("br_top",      1,  1,  32'hFFFF_FFFC,0,  26'h0,     0,  1,  32'hFFFF_FFFC, 32'h0000_0000);
        addVec("wrap",        0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_0000, 32'h0000_0004);
        addVec("after_wrap",  0,  0,  32'h0,        0,  26'h0,     0,  1,  32'h0000_0004, 32'h0000_0008);

        // Reset with InstrReady already high: BOOT must not advance PC.
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 26'h0, 0, 0, 1);
        #12;
        checkAll("reset", 32'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("reset_pcplus4", pc_plus4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        stepClock();
        checkAll("boot_exit", 32'h0, 2'b01, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].branch, vecs[i].zero, vecs[i].pc_branch, vecs[i].jump,
                          vecs[i].jump_addr, vecs[i].stall, 1'b0, vecs[i].instr_ready);
            stepClock();
            checkOutput({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
            checkOutput({vecs[i].name, "_pcplus4"}, pc_plus4, vecs[i].exp_pc_plus4);
            checkOutput({vecs[i].name, "_state"}, {30'd0, state}, {30'd0, vecs[i].exp_state});
            checkOutput({vecs[i].name, "_fetchreq"}, {31'd0, fetch_req}, {31'd0, vecs[i].exp_fetch_req});
        end

        // Misaligned taken branch traps with PC on the faulting instruction.
        @(negedge clk);
        applyStimulus(1, 1, 32'h22, 0, 26'h0, 0, 0, 1);
        stepClock();
        checkAll("trap", 32'h4, 2'b11, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(0, 0, 32'h0, 0, 26'h0, 0, 0, 1);
        stepClock();
        stepClock();
        checkAll("trap_hold", 32'h4, 2'b11, 1'b0, 1'b1);

        // Asynchronous reset between edges clears the trap at once.
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset_trap", 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stepClock();
        checkAll("reboot", 32'h0, 2'b01, 1'b1, 1'b0);
        stepClock();
        checkOutput("refetch0_pc", pc, 32'h4);
        stepClock();
        checkOutput("refetch1_pc", pc, 32'h8);

        // Halt beats InstrReady and stays until reset.
        @(negedge clk);
        applyStimulus(0, 0, 32'h0, 0, 26'h0, 0, 1, 1);
        stepClock();
        checkAll("halt", 32'h8, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1, 1, 32'h40, 1, 26'h5, 0, 0, 1);
        stepClock();
        stepClock();
        checkAll("halt_hold", 32'h8, 2'b10, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset_halt", 32'h0, 2'b00, 1'b0, 1'b0);

        // Mid-fetch reset discards an advanced PC.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 26'h0, 0, 0, 1);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("prefetch_pc", pc, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset_fetch", 32'h0, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
